// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage RV32I pipeline.
//   Owns PCF, issues single-outstanding requests to instruction memory,
//   absorbs memory latency and hazard stalls/flushes, discards responses
//   made stale by an Execute redirect, and drives the IF/ID register.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   StallF, StallD, FlushD   hazard-unit controls
//   PCSrcE, PCTargetE        Execute-stage redirect and its target
//   imem_req, imem_addr      request strobe (one cycle per request) and address
//   imem_rvalid, imem_rdata  in-order response, >=1 cycle after the request
//   InstrD, PCD, PCPlus4D    IF/ID register contents
//   ValidD                   IF/ID holds a real instruction (0 = bubble)
//
// Optional feature macro FETCH_PERF_EN: adds FetchCountF (deliveries) and
// BubbleCountF (non-flush bubbles loaded into IF/ID), both wrapping 32-bit.
//
// state | meaning
// ------+-------------------------------------------------------------
// ISSUE | no request outstanding; issue one at PCF unless stalled/redirected
// WAIT  | request at PCF outstanding, response still wanted
// DROP  | request outstanding but stale after a redirect; discard response
// HOLD  | response captured in hold buffer, waiting for IF/ID to accept it

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FetchCountF,
  output logic [31:0] BubbleCountF
`endif
);

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_target;
  logic [31:0] pcf_plus4;
  logic        deliver_ok;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic        issue;

  // Low target bits are dropped; PCF stays word aligned.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^PCTargetE[1:0];

  assign pc_target  = {PCTargetE[31:2], 2'b00};
  assign pcf_plus4  = pcf_q + 32'd4;
  // IF/ID can accept a new instruction only when decode is neither
  // stalled nor flushed and no redirect is in progress.
  assign deliver_ok = !StallD && !FlushD && !PCSrcE;

  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    hold_d        = hold_q;
    deliver       = 1'b0;
    deliver_instr = hold_q;
    issue         = 1'b0;

    case (state_q)
      ST_ISSUE: begin
        // A response arriving here is a protocol violation and is ignored.
        if (PCSrcE) begin
          pcf_d = pc_target;
        end else if (!StallF) begin
          issue   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (PCSrcE) begin
            pcf_d   = pc_target;
            state_d = ST_ISSUE;
          end else if (deliver_ok) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            state_d       = ST_ISSUE;
          end else begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (PCSrcE) begin
          pcf_d   = pc_target;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        // A further redirect retargets PCF; the outstanding response is
        // still owed by the memory and must be swallowed first.
        if (PCSrcE) begin
          pcf_d = pc_target;
        end
        if (imem_rvalid) begin
          state_d = ST_ISSUE;
        end
      end
      ST_HOLD: begin
        if (PCSrcE) begin
          pcf_d   = pc_target;
          state_d = ST_ISSUE;
        end else if (deliver_ok && !StallF) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          state_d       = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase

    if (deliver) begin
      pcf_d = pcf_plus4;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (deliver) begin
        instr_d = deliver_instr;
        pcd_d   = pcf_q;
        pcp4_d  = pcf_plus4;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ISSUE;
      pcf_q   <= RESET_PC;
      hold_q  <= 32'd0;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  // Request is combinational so a 1-cycle memory sustains one instruction
  // every two cycles; it is forced low while reset is held.
  assign imem_req  = issue && !rst;
  assign imem_addr = pcf_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign ValidD    = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (deliver) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (!FlushD && !StallD && !deliver) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FetchCountF  = fetch_cnt_q;
  assign BubbleCountF = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCountF, BubbleCountF;
`endif

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_EN
    , .FetchCountF(FetchCountF), .BubbleCountF(BubbleCountF)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: fetch progress expressed as "request outstanding",
  // "outstanding response is stale" and "captured word waiting".
  logic [31:0] m_pc, m_bufw, m_instr, m_pcd, m_pcp4;
  bit          m_out, m_stale, m_buf, m_valid;
  logic [31:0] m_fetch, m_bub;

  // Memory environment
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg;
  bit          req_seen;
  logic [31:0] addr_seen;
  logic [31:0] watch_pc;
  int          watch_hits;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_out = 0; m_stale = 0; m_buf = 0; m_bufw = 0;
    m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
    m_fetch = 0; m_bub = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = 0;
    imem_rvalid = 0; imem_rdata = 0;
  endtask

  task automatic model_step();
    bit          dok, dlv;
    logic [31:0] tgt, dw;
    dok = !StallD && !FlushD && !PCSrcE;
    tgt = PCTargetE & 32'hFFFF_FFFC;
    dlv = 0;
    dw  = 0;
    if (m_out && !m_stale) begin
      if (imem_rvalid) begin
        m_out = 0;
        if (PCSrcE) m_pc = tgt;
        else if (dok) begin dlv = 1; dw = mem_word(m_pc); end
        else begin m_buf = 1; m_bufw = mem_word(m_pc); end
      end else if (PCSrcE) begin
        m_pc = tgt; m_stale = 1;
      end
    end else if (m_out) begin
      if (PCSrcE) m_pc = tgt;
      if (imem_rvalid) begin m_out = 0; m_stale = 0; end
    end else if (m_buf) begin
      if (PCSrcE) begin m_buf = 0; m_pc = tgt; end
      else if (dok && !StallF) begin dlv = 1; dw = m_bufw; m_buf = 0; end
    end else begin
      if (PCSrcE) m_pc = tgt;
      else if (!StallF) m_out = 1;
    end
    if (FlushD) begin
      m_instr = NOP; m_valid = 0;
    end else if (!StallD) begin
      if (dlv) begin
        m_instr = dw; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1;
      end else begin
        m_instr = NOP; m_valid = 0;
      end
    end
    if (dlv) m_fetch = m_fetch + 1;
    if (!FlushD && !StallD && !dlv) m_bub = m_bub + 1;
    if (dlv) m_pc = m_pc + 32'd4;
  endtask

  // One clock: check request at negedge, advance model/memory at posedge,
  // check IF/ID just after the edge, then drive the memory response.
  task automatic tick();
    bit exp_req;
    @(negedge clk);
    exp_req = !m_out && !m_buf && !StallF && !PCSrcE;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    req_seen  = imem_req;
    addr_seen = imem_addr;
    @(posedge clk);
    model_step();
    if (imem_rvalid) mem_busy = 0;
    if (req_seen) begin
      mem_busy = 1;
      mem_addr = addr_seen;
      mem_cnt  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
    end
    #1;
    chk("InstrD", InstrD, m_instr);
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pcp4);
    chk("ValidD", ValidD, m_valid);
`ifdef FETCH_PERF_EN
    chk("FetchCountF", FetchCountF, m_fetch);
    chk("BubbleCountF", BubbleCountF, m_bub);
`endif
    if (ValidD && PCD == watch_pc) watch_hits++;
    imem_rvalid = 0;
    imem_rdata  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1;
        imem_rdata  = mem_word(mem_addr);
      end
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    PCSrcE = 1; PCTargetE = t;
    tick();
    PCSrcE = 0;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (req_seen) return;
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n_valid, bub;
    bit found;
    rst = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    lat_cfg = 1; watch_pc = 32'hFFFF_FFFF; watch_hits = 0;
    req_seen = 0; addr_seen = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcp4", PCPlus4D, 32'd0);
    chk("rst_valid", ValidD, 1'b0);
    rst = 0;

    // 1-cycle memory: alternate-cycle requests
    tick();
    chk("t1_req0", req_seen, 1'b1);
    chk("t1_addr0", addr_seen, 32'h100);
    tick();
    chk("t1_instr", InstrD, 32'hA5A5_0100);
    chk("t1_pcd", PCD, 32'h100);
    chk("t1_pcp4", PCPlus4D, 32'h104);
    chk("t1_valid", ValidD, 1'b1);
    tick();
    chk("t1_addr1", addr_seen, 32'h104);
    tick();
    tick();
    chk("t1_addr2", addr_seen, 32'h108);

    // 3-cycle memory: bubbles between consecutive valid instructions
    lat_cfg = 3;
    n_valid = 0; bub = 0;
    for (int i = 0; i < 40 && n_valid < 2; i++) begin
      tick();
      if (ValidD) n_valid++;
      else if (n_valid == 1) bub++;
    end
    chk("t2_two_valid", n_valid, 2);
    chk("t2_bubbles", bub, 3);

    // StallD spanning the response: captured, then delivered
    lat_cfg = 2;
    redirect(32'h10);
    wait_req("t3_req");
    chk("t3_addr", addr_seen, 32'h10);
    StallD = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_noreq", req_seen, 1'b0);
    end
    StallD = 0;
    tick();
    chk("t3_pcd", PCD, 32'h10);
    chk("t3_valid", ValidD, 1'b1);
    tick();
    chk("t3_next_req", req_seen, 1'b1);
    chk("t3_next_addr", addr_seen, 32'h14);

    // Redirect while waiting: stale response discarded
    lat_cfg = 3;
    redirect(32'h40);
    wait_req("t4_req");
    chk("t4_addr", addr_seen, 32'h40);
    watch_pc = 32'h40; watch_hits = 0;
    redirect(32'h203);
    wait_req("t4_req2");
    chk("t4_addr2", addr_seen, 32'h200);
    for (int i = 0; i < 6; i++) tick();
    chk("t4_stale_seen", watch_hits, 0);
    watch_pc = 32'hFFFF_FFFF;

    // PC wrap
    lat_cfg = 1;
    redirect(32'hFFFF_FFFC);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ValidD && PCD == 32'hFFFF_FFFC) found = 1;
    end
    chk("t5_found", found, 1'b1);
    chk("t5_pcp4", PCPlus4D, 32'h0);
    wait_req("t5_req");
    chk("t5_addr", addr_seen, 32'h0);

    // Async reset mid-WAIT
    lat_cfg = 3;
    wait_req("t6_req");
    #2 rst = 1;
    #1;
    chk("t6_req", imem_req, 1'b0);
    chk("t6_addr", imem_addr, RST_PC);
    chk("t6_instr", InstrD, NOP);
    chk("t6_pcd", PCD, 32'd0);
    chk("t6_pcp4", PCPlus4D, 32'd0);
    chk("t6_valid", ValidD, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    tick();
    chk("t6_first_req", req_seen, 1'b1);
    chk("t6_first_addr", addr_seen, RST_PC);
    for (int i = 0; i < 6; i++) tick();

    // Randomized hazards, redirects and latencies
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      StallF    = ($urandom_range(0, 99) < 15);
      StallD    = ($urandom_range(0, 99) < 15);
      FlushD    = ($urandom_range(0, 99) < 8);
      PCSrcE    = ($urandom_range(0, 99) < 8);
      PCTargetE = $urandom;
      if ($urandom_range(0, 9) == 0) PCTargetE = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      tick();
    end
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    for (int i = 0; i < 10; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline. It is the producer side of the IF/ID interface consumed by the decode stage.
- Owns the PC register and issues single-outstanding requests to the instruction memory.
- Absorbs variable memory latency and hazard-unit stalls/flushes, and discards responses made stale by an Execute-stage redirect.
- Drives InstrD/PCD/PCPlus4D through the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on InstrD when no valid instruction.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
StallF  input  1  hazard unit: hold PC, issue no new request
StallD  input  1  hazard unit: hold IF/ID register
FlushD  input  1  hazard unit: force bubble into IF/ID
PCSrcE  input  1  Execute redirect (taken branch/jump)
PCTargetE  input  32  redirect target
imem_req  output  1  request strobe, one cycle per request
imem_addr  output  32  request address (=PCF)
imem_rvalid  input  1  response valid, >=1 cycle after imem_req, in order
imem_rdata  input  32  response instruction word
InstrD  output  32  IF/ID instruction
PCD  output  32  IF/ID PC
PCPlus4D  output  32  IF/ID PC+4
ValidD  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- One clock (clk); reset asynchronous, active-high (rst).
- Reset values: PCF=RESET_PC, state=ISSUE, hold buffer empty, imem_req=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
- Address rules:
  - PCF[1:0] is always 00; PCTargetE[1:0] is ignored.
  - PC+4 wraps modulo 2^32.
- "Deliver" means: StallD=0, FlushD=0, PCSrcE=0. Delivery loads IF/ID with {instr, PCF, PCF+4} and ValidD=1, then sets PCF<=PCF+4.
- FSM states:
  - ISSUE:
    - imem_req=1, imem_addr=PCF, unless StallF=1 or PCSrcE=1; then req=0.
    - Request issued -> WAIT.
    - PCSrcE=1 -> PCF<=PCTargetE, stay ISSUE.
  - WAIT (req=0), conditions in priority order:
    - rvalid & PCSrcE -> discard, PCF<=target, ->ISSUE.
    - rvalid & deliver -> deliver, ->ISSUE.
    - rvalid & StallF=0 but not deliver -> store rdata in hold buffer, ->HOLD.
    - rvalid & StallF=1 -> store in hold buffer, ->HOLD.
    - no rvalid & PCSrcE -> PCF<=target, ->DROP.
  - DROP (req=0):
    - rvalid -> discard, ->ISSUE.
    - PCSrcE -> PCF<=target, stay DROP.
  - HOLD (req=0):
    - PCSrcE -> empty buffer, PCF<=target, ->ISSUE.
    - deliver & StallF=0 -> deliver from buffer, ->ISSUE.
    - otherwise remain in HOLD.
- IF/ID register rules:
  - FlushD=1 -> NOP_INSTR / ValidD=0. FlushD has priority over StallD.
  - Else StallD=1 -> hold.
  - Else, with no delivery this cycle -> bubble (NOP_INSTR, ValidD=0; PCD/PCPlus4D hold their last values).
- imem_rvalid in ISSUE is a protocol violation and is ignored.
- Latency: a 1-cycle memory gives one instruction every 2 cycles. The first request is issued in the first clock after rst deasserts.
- Reset asserted mid-WAIT/DROP: immediate return to reset values. The memory shares rst, so no stale response survives reset.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs FetchCountF[31:0] (increments on each delivery) and BubbleCountF[31:0] (increments on each cycle IF/ID loads a bubble due to a non-flush cause). Both reset to 0 and wrap at 2^32.
- Undefined: no ports, no counter logic.

Test Plan:
1. RESET_PC=0x100, 1-cycle memory returning addr^0xA5A50000 -> req at 0x100, 0x104, 0x108 on alternate cycles; InstrD=0xA5A50100 with PCD=0x100, PCPlus4D=0x104, ValidD=1.
2. 3-cycle memory latency -> exactly 3 bubble cycles (ValidD=0, InstrD=0x13) between consecutive valid instructions; no second req while one is outstanding.
3. StallD=1 for 4 cycles covering rvalid at PC 0x10 -> HOLD entered, no req, InstrD unchanged. First cycle after StallD=0 -> PCD=0x10, then req at 0x14.
4. PCSrcE=1, PCTargetE=0x203 while in WAIT at PC 0x40 -> DROP. The late rvalid is discarded (InstrD never shows PCD=0x40). Next req addr=0x200.
5. PCF=0xFFFF_FFFC delivered -> PCPlus4D=0x0000_0000, next imem_addr=0x0.
6. rst pulsed asynchronously (mid-cycle) during WAIT -> outputs return to reset values immediately. After release, first req at RESET_PC and ValidD=0 until the first response.
